// File: rtl/tdi_sim_trig_gen.sv
// Simulated TDI line-trigger source: one trigger per line period for the valid
// lines of each track, idle gap lines to the track length, repeated per track.
module tdi_sim_trig_gen #(
    parameter int unsigned TDI_sim_CLK = 200_000_000,
    parameter int unsigned TRIG_period = TDI_sim_CLK / 1_000_000,
    parameter int unsigned TRACK_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sim_en,
    input  logic [31:0]            sim_track_valid_line_cnt,
    input  logic [31:0]            sim_track_total_line_cnt,
    input  logic [TRACK_CNT_W-1:0] sim_track_num,
    input  logic                   INFO_fifo_prog_full,
    output logic                   TDI_trigger,
    output logic                   track_tlast,
    output logic [31:0]            line_idx,
    output logic [TRACK_CNT_W-1:0] track_idx,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            stall_cnt
);

    localparam int unsigned PW = $clog2(TRIG_period);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(TRIG_period - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   sim_en_q;
    logic [31:0]            cfg_v;
    logic [31:0]            cfg_t;
    logic [TRACK_CNT_W-1:0] cfg_n;
    logic [PW-1:0]          period_cnt;

    logic                   start_c;
    logic                   tick_c;
    logic                   valid_line_c;
    logic                   fire_c;
    logic                   stall_c;
    logic                   advance_c;
    logic                   last_line_c;
    logic                   final_c;
    logic [31:0]            total_c;

    logic                   trigger_d;
    logic                   tlast_d;
    logic                   busy_d;
    logic                   done_d;

    // Line-tick decode; an sim_en drop in RUN suppresses everything this cycle.
    assign start_c      = sim_en & ~sim_en_q;
    assign tick_c       = (state == RUN) & sim_en & (period_cnt == PERIOD_LAST);
    assign valid_line_c = (line_idx < cfg_v);
    assign fire_c       = tick_c & valid_line_c & ~INFO_fifo_prog_full;
    assign stall_c      = tick_c & valid_line_c & INFO_fifo_prog_full;
    assign advance_c    = fire_c | (tick_c & ~valid_line_c);
    assign last_line_c  = (line_idx == cfg_t - 32'd1);
    assign final_c      = advance_c & last_line_c & (cfg_n != '0) &
                          (track_idx == cfg_n - TRACK_CNT_W'(1));

    // Track length clamps to at least the valid count and at least one line.
    always_comb begin
        total_c = sim_track_total_line_cnt;
        if (sim_track_valid_line_cnt > total_c) begin
            total_c = sim_track_valid_line_cnt;
        end
        if (total_c == 32'd0) begin
            total_c = 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_c) state_nxt = RUN;
            RUN: begin
                if (!sim_en) begin
                    state_nxt = IDLE;
                end else if (final_c) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        trigger_d = fire_c;
        tlast_d   = fire_c & (line_idx == cfg_v - 32'd1);
        done_d    = (state == RUN) & (state_nxt == DONE);
        busy_d    = (state_nxt == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            TDI_trigger <= 1'b0;
            track_tlast <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            TDI_trigger <= trigger_d;
            track_tlast <= tlast_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Config latch, period/line/track counters and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sim_en_q   <= 1'b0;
            cfg_v      <= '0;
            cfg_t      <= '0;
            cfg_n      <= '0;
            period_cnt <= '0;
            line_idx   <= '0;
            track_idx  <= '0;
            stall_cnt  <= '0;
        end else begin
            sim_en_q <= sim_en;
            if (state == IDLE && start_c) begin
                cfg_v      <= sim_track_valid_line_cnt;
                cfg_t      <= total_c;
                cfg_n      <= sim_track_num;
                period_cnt <= '0;
                line_idx   <= '0;
                track_idx  <= '0;
                stall_cnt  <= '0;
            end else if (state == RUN && sim_en) begin
                if (period_cnt != PERIOD_LAST) begin
                    period_cnt <= period_cnt + PW'(1);
                end else if (!stall_c) begin
                    period_cnt <= '0;
                end
                if (stall_c && stall_cnt != 32'hFFFF_FFFF) begin
                    stall_cnt <= stall_cnt + 32'd1;
                end
                if (advance_c) begin
                    if (last_line_c) begin
                        line_idx  <= '0;
                        track_idx <= track_idx + TRACK_CNT_W'(1);
                    end else begin
                        line_idx <= line_idx + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdi_sim_trig_gen.sv
// Bench for tdi_sim_trig_gen: runs each scenario, records event times per run
// and compares them with a line-level timing model.
module tb_tdi_sim_trig_gen;

    localparam int P  = 200;
    localparam int TW = 16;
    localparam int NO_ABORT = 1 << 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sim_en = 1'b0;
    logic [31:0]   valid_cnt = '0;
    logic [31:0]   total_cnt = '0;
    logic [TW-1:0] track_num = '0;
    logic          prog_full = 1'b0;
    logic          trig;
    logic          tlast;
    logic [31:0]   line_idx;
    logic [TW-1:0] track_idx;
    logic          busy;
    logic          done;
    logic [31:0]   stall_cnt;

    int checks = 0;
    int errors = 0;

    int obs_trig[$];
    int obs_tlast[$];
    int obs_done;
    int start_line, start_track, start_stall, start_busy;
    int exp_trig[$];
    int exp_tlast[$];
    int exp_done, exp_stall, exp_line, exp_track;

    tdi_sim_trig_gen #(
        .TDI_sim_CLK(200_000_000),
        .TRIG_period(P),
        .TRACK_CNT_W(TW)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .sim_en                  (sim_en),
        .sim_track_valid_line_cnt(valid_cnt),
        .sim_track_total_line_cnt(total_cnt),
        .sim_track_num           (track_num),
        .INFO_fifo_prog_full     (prog_full),
        .TDI_trigger             (trig),
        .track_tlast             (tlast),
        .line_idx                (line_idx),
        .track_idx               (track_idx),
        .busy                    (busy),
        .done                    (done),
        .stall_cnt               (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic int first_diff(input int a[$], input int b[$]);
        int n = (a.size() > b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) begin
            if (i >= a.size() || i >= b.size()) return i;
            if (a[i] != b[i]) return i;
        end
        return -1;
    endfunction

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    // Line-level model: each line lasts P cycles after the previous tick; a
    // valid line waits out prog_full one cycle at a time before its trigger.
    // Times are edges counted from the start edge (edge 0).
    task automatic model_run(input int v, input int tot, input int n,
                             input int lo, input int hi, input int ab, input int lim);
        int t = 0;
        int tt, ln, trk, stall;
        bit stop = 0;
        tt = (tot > v) ? tot : v;
        if (tt == 0) tt = 1;
        ln = 0; trk = 0; stall = 0;
        exp_trig.delete(); exp_tlast.delete(); exp_done = -1;
        while (!stop) begin
            t += P;
            if (t > ab || t > lim) begin
                stop = 1;
            end else begin
                if (ln < v) begin
                    while (!stop && t >= lo && t <= hi) begin
                        stall++;
                        t++;
                        if (t > ab || t > lim) stop = 1;
                    end
                    if (!stop) begin
                        exp_trig.push_back(t);
                        if (ln == v - 1) exp_tlast.push_back(t);
                    end
                end
                if (!stop) begin
                    if (ln == tt - 1) begin
                        ln = 0;
                        if (n != 0 && trk == n - 1) begin
                            exp_done = t;
                            stop = 1;
                        end
                        trk = (trk + 1) % (1 << TW);
                    end else begin
                        ln++;
                    end
                end
            end
        end
        exp_stall = stall; exp_line = ln; exp_track = trk;
    endtask

    // Starts a run and records outputs after each edge 1..lim.
    task automatic run_capture(input int v, input int tot, input int n,
                               input int lo, input int hi, input int ab, input int lim);
        obs_trig.delete(); obs_tlast.delete(); obs_done = -1;
        @(negedge clk);
        sim_en = 1'b0; prog_full = 1'b0;
        valid_cnt = 32'(v); total_cnt = 32'(tot); track_num = TW'(n);
        repeat (2) @(negedge clk);
        sim_en = 1'b1;
        @(negedge clk);
        start_line = int'(line_idx); start_track = int'(track_idx);
        start_stall = int'(stall_cnt); start_busy = int'(busy);
        prog_full = (1 >= lo && 1 <= hi);
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            if (trig === 1'b1) obs_trig.push_back(k);
            if (tlast === 1'b1) obs_tlast.push_back(k);
            if (done === 1'b1 && obs_done < 0) obs_done = k;
            if (k == ab) sim_en = 1'b0;
            prog_full = (k + 1 >= lo && k + 1 <= hi);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({trig, tlast, busy, done} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {trig, tlast, busy, done});
        end
        checks++;
        if (line_idx !== 32'd0 || track_idx !== '0 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_counters got line %0d track %0d stall %0d exp 0 0 0",
                               line_idx, track_idx, stall_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int d;
        model_run(4, 6, 2, NO_ABORT, 0, NO_ABORT, 50000);
        run_capture(4, 6, 2, NO_ABORT, 0, NO_ABORT, exp_done + 10);
        checks++; d = first_diff(obs_trig, exp_trig);
        if (d >= 0) begin
            errors++; $display("FAIL basic_trig idx %0d got %0d exp %0d", d, at(obs_trig, d), at(exp_trig, d));
        end
        checks++; d = first_diff(obs_tlast, exp_tlast);
        if (d >= 0) begin
            errors++; $display("FAIL basic_tlast idx %0d got %0d exp %0d", d, at(obs_tlast, d), at(exp_tlast, d));
        end
        checks++;
        if (obs_done !== 2400) begin
            errors++; $display("FAIL basic_done got %0d exp 2400", obs_done);
        end
        checks++;
        if (busy !== 1'b0 || start_busy !== 1) begin
            errors++; $display("FAIL basic_busy got start %0d end %0b exp 1 0", start_busy, busy);
        end
        checks++;
        if (int'(track_idx) !== exp_track || int'(line_idx) !== exp_line) begin
            errors++; $display("FAIL basic_idx got %0d/%0d exp %0d/%0d", track_idx, line_idx, exp_track, exp_line);
        end
    endtask

    task automatic test_backpressure();
        int d;
        model_run(4, 6, 2, 390, 450, NO_ABORT, 50000);
        run_capture(4, 6, 2, 390, 450, NO_ABORT, exp_done + 10);
        checks++; d = first_diff(obs_trig, exp_trig);
        if (d >= 0) begin
            errors++; $display("FAIL bp_trig idx %0d got %0d exp %0d", d, at(obs_trig, d), at(exp_trig, d));
        end
        checks++;
        if (at(obs_trig, 1) !== 451 || at(obs_trig, 2) !== 651) begin
            errors++; $display("FAIL bp_delay got %0d %0d exp 451 651", at(obs_trig, 1), at(obs_trig, 2));
        end
        checks++;
        if (stall_cnt !== 32'd51) begin
            errors++; $display("FAIL bp_stall got %0d exp 51", stall_cnt);
        end
        checks++;
        if (obs_done !== exp_done) begin
            errors++; $display("FAIL bp_done got %0d exp %0d", obs_done, exp_done);
        end
    endtask

    task automatic test_edge_cfg();
        int d;
        model_run(0, 3, 1, NO_ABORT, 0, NO_ABORT, 50000);
        run_capture(0, 3, 1, NO_ABORT, 0, NO_ABORT, exp_done + 10);
        checks++;
        if (obs_trig.size() != 0 || obs_tlast.size() != 0) begin
            errors++; $display("FAIL v0_pulses got %0d/%0d exp 0/0", obs_trig.size(), obs_tlast.size());
        end
        checks++;
        if (obs_done !== 3 * P) begin
            errors++; $display("FAIL v0_done got %0d exp %0d", obs_done, 3 * P);
        end
        model_run(5, 2, 1, NO_ABORT, 0, NO_ABORT, 50000);
        run_capture(5, 2, 1, NO_ABORT, 0, NO_ABORT, exp_done + 10);
        checks++; d = first_diff(obs_trig, exp_trig);
        if (d >= 0 || obs_trig.size() != 5) begin
            errors++; $display("FAIL clamp_trig idx %0d got %0d exp %0d", d, at(obs_trig, d), at(exp_trig, d));
        end
        checks++;
        if (obs_done !== 5 * P || at(obs_tlast, 0) !== 5 * P) begin
            errors++; $display("FAIL clamp_done got %0d tlast %0d exp %0d", obs_done, at(obs_tlast, 0), 5 * P);
        end
    endtask

    task automatic test_abort();
        int d;
        model_run(4, 6, 2, 395, 410, 500, 1500);
        run_capture(4, 6, 2, 395, 410, 500, 1500);
        checks++; d = first_diff(obs_trig, exp_trig);
        if (d >= 0) begin
            errors++; $display("FAIL abort_trig idx %0d got %0d exp %0d", d, at(obs_trig, d), at(exp_trig, d));
        end
        checks++;
        if (obs_done !== -1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_end got done %0d busy %0b exp -1 0", obs_done, busy);
        end
        checks++;
        if (int'(line_idx) !== exp_line || int'(stall_cnt) !== exp_stall) begin
            errors++; $display("FAIL abort_hold got %0d/%0d exp %0d/%0d", line_idx, stall_cnt, exp_line, exp_stall);
        end
        run_capture(1, 1, 1, NO_ABORT, 0, NO_ABORT, P + 5);
        checks++;
        if (start_line !== 0 || start_track !== 0 || start_stall !== 0 || start_busy !== 1) begin
            errors++; $display("FAIL restart got line %0d track %0d stall %0d busy %0d exp 0 0 0 1",
                               start_line, start_track, start_stall, start_busy);
        end
    endtask

    task automatic test_rst_midrun();
        model_run(4, 6, 2, NO_ABORT, 0, NO_ABORT, 2 * P - 1);
        run_capture(4, 6, 2, NO_ABORT, 0, NO_ABORT, 2 * P - 1);
        checks++;
        if (int'(line_idx) !== exp_line || busy !== 1'b1) begin
            errors++; $display("FAIL pre_rst got line %0d busy %0b exp %0d 1", line_idx, busy, exp_line);
        end
        rst = 1'b1; sim_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({trig, tlast, busy, done} !== 4'b0 || line_idx !== 32'd0 || track_idx !== '0) begin
            errors++; $display("FAIL mid_rst got flags %b line %0d track %0d exp 0", {trig, tlast, busy, done},
                               line_idx, track_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_endless();
        int d;
        model_run(1, 1, 0, NO_ABORT, 0, NO_ABORT, 10 * P + 5);
        run_capture(1, 1, 0, NO_ABORT, 0, NO_ABORT, 10 * P + 5);
        checks++; d = first_diff(obs_trig, exp_trig);
        if (d >= 0 || obs_trig.size() != 10) begin
            errors++; $display("FAIL endless_trig idx %0d got %0d exp %0d", d, at(obs_trig, d), at(exp_trig, d));
        end
        checks++; d = first_diff(obs_tlast, exp_tlast);
        if (d >= 0) begin
            errors++; $display("FAIL endless_tlast idx %0d got %0d exp %0d", d, at(obs_tlast, d), at(exp_tlast, d));
        end
        checks++;
        if (int'(track_idx) !== exp_track || busy !== 1'b1 || obs_done !== -1) begin
            errors++; $display("FAIL endless_state got track %0d busy %0b done %0d exp %0d 1 -1",
                               track_idx, busy, obs_done, exp_track);
        end
    endtask

    task automatic test_random();
        int d, v, tot, n, lo, hi;
        for (int it = 0; it < 4; it++) begin
            v   = $urandom_range(0, 4);
            tot = $urandom_range(0, 6);
            n   = $urandom_range(1, 3);
            lo  = $urandom_range(150, 1200);
            hi  = lo + $urandom_range(0, 80);
            model_run(v, tot, n, lo, hi, NO_ABORT, 50000);
            run_capture(v, tot, n, lo, hi, NO_ABORT, exp_done + 10);
            checks++; d = first_diff(obs_trig, exp_trig);
            if (d >= 0) begin
                errors++; $display("FAIL rand%0d_trig v%0d t%0d n%0d idx %0d got %0d exp %0d",
                                   it, v, tot, n, d, at(obs_trig, d), at(exp_trig, d));
            end
            checks++; d = first_diff(obs_tlast, exp_tlast);
            if (d >= 0) begin
                errors++; $display("FAIL rand%0d_tlast idx %0d got %0d exp %0d", it, d, at(obs_tlast, d), at(exp_tlast, d));
            end
            checks++;
            if (obs_done !== exp_done || int'(stall_cnt) !== exp_stall) begin
                errors++; $display("FAIL rand%0d_end got done %0d stall %0d exp %0d %0d",
                                   it, obs_done, stall_cnt, exp_done, exp_stall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_edge_cfg();
        test_abort();
        test_rst_midrun();
        test_endless();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
